// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction-memory port arbiter.
// Two requesters share one port: F (fetch, read-only) and L (loader, read/write).
package imem_port_arbiter_pkg;

  localparam int ADDR_W_DEF    = 10;
  localparam int DATA_W_DEF    = 32;
  localparam int MAX_BURST_DEF = 8;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_L = 1'b1
  } port_e;

endpackage

// File: rtl/imem_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that did not win last time.
module imem_rr_pick
  import imem_port_arbiter_pkg::*;
(
  input  logic req_f,
  input  logic req_l,
  input  logic last_winner,
  output logic pick_f,
  output logic pick_l
);

  always_comb begin
    pick_f = req_f & (~req_l | (last_winner == PORT_L));
    pick_l = req_l & ~pick_f;
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction memory between fetch and loader,
// with a loader burst-lock mode that still lets fetch in every MAX_BURST grants.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int             CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  arb_state_e       state_q, state_d;
  port_e            last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             f_rvalid_q, f_rvalid_d;
  logic             l_rvalid_q, l_rvalid_d;
  logic             rr_f, rr_l;

  imem_rr_pick u_rr_pick (
    .req_f       (f_req),
    .req_l       (l_req),
    .last_winner (last_q),
    .pick_f      (rr_f),
    .pick_l      (rr_l)
  );

  // NOTE: every signal gets a default first so no path through the block infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    f_gnt   = 1'b0;
    l_gnt   = 1'b0;

    unique case (state_q)
      ARB: begin
        f_gnt = rr_f;
        l_gnt = rr_l;
        if (l_gnt && l_lock) begin
          state_d = LOCKED;
          cnt_d   = CNT_W'(1);
        end
      end
      LOCKED: begin
        if (l_req && (!f_req || cnt_q < MAX_CNT)) begin
          l_gnt = 1'b1;
          cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (l_req) begin
          // Starvation limit reached: fetch gets one slot, burst keeps ownership.
          f_gnt = 1'b1;
          cnt_d = '0;
        end else begin
          f_gnt = f_req;
        end
        if (!l_lock && (l_gnt || !l_req)) begin
          state_d = ARB;
          cnt_d   = '0;
        end
      end
    endcase

    // Grants are suppressed while reset is held, even though it is asynchronous.
    if (!reset) begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
    end

    if (f_gnt)      last_d = PORT_F;
    else if (l_gnt) last_d = PORT_L;

    f_rvalid_d = f_gnt;
    l_rvalid_d = l_gnt & ~l_we;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB;
      last_q     <= PORT_L;
      cnt_q      <= '0;
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      f_rvalid_q <= f_rvalid_d;
      l_rvalid_q <= l_rvalid_d;
    end
  end

  always_comb begin
    mem_en    = f_gnt | l_gnt;
    mem_we    = l_gnt & l_we;
    mem_addr  = f_gnt ? f_addr : (l_gnt ? l_addr : '0);
    mem_wdata = l_gnt ? l_wdata : '0;
    f_rvalid  = f_rvalid_q;
    l_rvalid  = l_rvalid_q;
    f_rdata   = f_rvalid_q ? mem_rdata : '0;
    l_rdata   = l_rvalid_q ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a small 1-cycle-latency memory
// attached; word i of the memory starts as 32'h1000_0000 + i.
module tb_imem_port_arbiter;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        f_req = 1'b0;
  logic [9:0]  f_addr = '0;
  logic        f_gnt, f_rvalid;
  logic [31:0] f_rdata;
  logic        l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
  logic [9:0]  l_addr = '0;
  logic [31:0] l_wdata = '0;
  logic        l_gnt, l_rvalid;
  logic [31:0] l_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  imem_port_arbiter dut (
    .CLK       (CLK),
    .reset     (reset),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_gnt     (f_gnt),
    .f_rvalid  (f_rvalid),
    .f_rdata   (f_rdata),
    .l_req     (l_req),
    .l_we      (l_we),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_lock    (l_lock),
    .l_gnt     (l_gnt),
    .l_rvalid  (l_rvalid),
    .l_rdata   (l_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Memory model: single process owns the array and the read register.
  logic [31:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    mem_rdata = '0;
    forever begin
      @(posedge CLK);
      if (mem_en) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else        mem_rdata     <= mem[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    f_req  = 1'b0;
    l_req  = 1'b0;
    l_we   = 1'b0;
    l_lock = 1'b0;
    repeat (2) @(posedge CLK);
    #1 reset = 1'b1;
  endtask

  initial begin
    logic exp_f;
    int   wait_cnt;
    int   max_wait;

    // Reset state
    do_reset();
    #1;
    check("rst_f_rvalid", f_rvalid, 0);
    check("rst_l_rvalid", l_rvalid, 0);
    check("rst_mem_en",   mem_en,   0);
    check("rst_mem_addr", mem_addr, 0);
    tick();

    // Fetch-only stream, addresses 0..3 back to back
    f_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f_addr = 10'(i);
      #1;
      check("fo_f_gnt",    f_gnt,    1);
      check("fo_l_gnt",    l_gnt,    0);
      check("fo_mem_addr", mem_addr, i);
      check("fo_mem_we",   mem_we,   0);
      tick();
      check("fo_f_rvalid", f_rvalid, 1);
      check("fo_f_rdata",  f_rdata,  32'h1000_0000 + i);
    end
    f_req = 1'b0;
    tick();
    check("fo_idle_rvalid", f_rvalid, 0);

    // Contested, unlocked: F,L,F,L from reset
    do_reset();
    f_req = 1'b1; f_addr = 10'd4;
    l_req = 1'b1; l_addr = 10'd7; l_we = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("rr_f_gnt", f_gnt, (c % 2) == 0);
      check("rr_l_gnt", l_gnt, (c % 2) == 1);
      check("rr_mem_addr", mem_addr, ((c % 2) == 0) ? 4 : 7);
      tick();
      check("rr_f_rvalid", f_rvalid, (c % 2) == 0);
      check("rr_l_rvalid", l_rvalid, (c % 2) == 1);
      if ((c % 2) == 1) check("rr_l_rdata", l_rdata, 32'h1000_0007);
      else              check("rr_f_rdata", f_rdata, 32'h1000_0004);
    end
    f_req = 1'b0; l_req = 1'b0;
    tick();

    // Loader write then fetch read-back
    l_req = 1'b1; l_we = 1'b1; l_addr = 10'd5; l_wdata = 32'hDEAD_BEEF;
    #1;
    check("wr_l_gnt",     l_gnt,     1);
    check("wr_mem_we",    mem_we,    1);
    check("wr_mem_addr",  mem_addr,  5);
    check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    check("wr_no_l_rvalid", l_rvalid, 0);
    l_req = 1'b0; l_we = 1'b0;
    f_req = 1'b1; f_addr = 10'd5;
    #1;
    check("rb_f_gnt",     f_gnt,     1);
    check("rb_mem_wdata", mem_wdata, 0);
    tick();
    check("rb_f_rdata", f_rdata, 32'hDEAD_BEEF);
    f_req = 1'b0;
    tick();

    // Locked burst with fetch pending: F, 8xL, F, 8xL, F, L
    do_reset();
    f_req = 1'b1; f_addr = 10'd1;
    l_req = 1'b1; l_addr = 10'd2; l_lock = 1'b1;
    wait_cnt = 0;
    max_wait = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      exp_f = (c == 0) || (c == 9) || (c == 18);
      check("lk_f_gnt", f_gnt, exp_f);
      check("lk_l_gnt", l_gnt, !exp_f);
      if (f_gnt) wait_cnt = 0;
      else begin
        wait_cnt++;
        if (wait_cnt > max_wait) max_wait = wait_cnt;
      end
      tick();
    end
    check("lk_f_max_wait", max_wait, 8);

    // Lock dropped on third locked L grant: back to ARB, next tie to F
    do_reset();
    f_req = 1'b1; l_req = 1'b1; l_lock = 1'b1;
    for (int c = 0; c < 7; c++) begin
      l_lock = (c < 3);
      #1;
      exp_f = (c == 0) || (c == 4) || (c == 6);
      check("ul_f_gnt", f_gnt, exp_f);
      check("ul_l_gnt", l_gnt, !exp_f);
      tick();
    end

    // Reset mid-burst with an L read in flight
    do_reset();
    f_req = 1'b1; f_addr = 10'd2;
    l_req = 1'b1; l_addr = 10'd9; l_lock = 1'b1;
    repeat (3) tick();
    check("mr_l_rvalid_inflight", l_rvalid, 1);
    check("mr_l_rdata_inflight",  l_rdata,  32'h1000_0009);
    reset = 1'b0;
    #1;
    check("mr_l_rvalid_dropped", l_rvalid, 0);
    check("mr_l_gnt_in_reset",   l_gnt,    0);
    check("mr_f_gnt_in_reset",   f_gnt,    0);
    check("mr_mem_en_in_reset",  mem_en,   0);
    tick();
    check("mr_f_gnt_in_reset2",  f_gnt,    0);
    check("mr_f_rvalid_reset",   f_rvalid, 0);
    reset  = 1'b1;
    l_lock = 1'b0;
    #1;
    check("mr_first_tie_f", f_gnt, 1);
    check("mr_first_tie_l", l_gnt, 0);
    tick();
    f_req = 1'b0; l_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
